// File: rtl/pe_act_reg_file_pkg.sv
// Shared defaults and types for the PE activation register file.
// The controller read mux imports the same widths, so both sides agree on the address width.
package pe_act_reg_file_pkg;

  localparam int ACT_NUM_DEF    = 16;
  localparam int ACT_WIDTH_DEF  = 16;
  localparam int ADDR_WIDTH_DEF = 4;

  // Selects where the registered read data comes from on the cycle after a read.
  typedef enum logic [1:0] {
    RD_SRC_ZERO = 2'd0,
    RD_SRC_MEM  = 2'd1,
    RD_SRC_BYP  = 2'd2
  } rd_src_e;

  function automatic logic addr_in_range(input int addr, input int depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/pe_act_mem.sv
// Raw activation storage: one write port, one registered read port, no reset on data.
// Can be built from a register array or mapped onto a memory macro.
module pe_act_mem
  import pe_act_reg_file_pkg::*;
#(
  parameter int DEPTH = ACT_NUM_DEF,
  parameter int WIDTH = ACT_WIDTH_DEF,
  parameter int AW    = ADDR_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/pe_act_reg_file.sv
// PE activation register file: storage plus per-layer valid bitmap, load counter,
// same-cycle write-first bypass and miss reporting for the controller's read mux.
module pe_act_reg_file
  import pe_act_reg_file_pkg::*;
#(
  parameter int ACT_NUM    = ACT_NUM_DEF,
  parameter int ACT_WIDTH  = ACT_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_act_write_en,
  input  logic [ADDR_WIDTH-1:0] in_act_write_addr,
  input  logic [ACT_WIDTH-1:0]  in_act_write_data,
  input  logic                  in_act_read_en,
  input  logic [ADDR_WIDTH-1:0] in_act_read_addr,
  output logic [ACT_WIDTH-1:0]  in_act_read_data,
  output logic                  in_act_read_valid,
  output logic                  in_act_read_miss,
  output logic [ADDR_WIDTH:0]   in_act_load_cnt,
  output logic                  in_act_loaded
);

  localparam logic [ADDR_WIDTH:0] ACT_NUM_CNT = (ADDR_WIDTH+1)'(ACT_NUM);

  logic                 wr_ok, rd_ok, rd_byp;
  logic [ACT_NUM-1:0]   vld_bits_q, vld_bits_d;
  logic [ADDR_WIDTH:0]  cnt_q, cnt_d;
  logic                 loaded_q, loaded_d;
  logic                 rd_vld_q, rd_vld_d;
  logic                 rd_miss_q, rd_miss_d;
  rd_src_e              rd_src_q, rd_src_d;
  logic [ACT_WIDTH-1:0] byp_data_q, byp_data_d;
  logic [ACT_WIDTH-1:0] mem_rdata;

  always_comb begin
    wr_ok  = in_act_write_en && !clear
             && addr_in_range(int'(in_act_write_addr), ACT_NUM);
    rd_ok  = in_act_read_en && addr_in_range(int'(in_act_read_addr), ACT_NUM);
    rd_byp = rd_ok && wr_ok && (in_act_write_addr == in_act_read_addr);

    vld_bits_d = vld_bits_q;
    cnt_d      = cnt_q;
    if (clear) begin
      vld_bits_d = '0;
      cnt_d      = '0;
    end else if (wr_ok) begin
      vld_bits_d[in_act_write_addr] = 1'b1;
      if (!vld_bits_q[in_act_write_addr]) cnt_d = cnt_q + (ADDR_WIDTH+1)'(1);
    end
    loaded_d = (cnt_d == ACT_NUM_CNT);

    // Read response is decided now; the data source is held until the next read.
    rd_vld_d   = in_act_read_en;
    rd_miss_d  = 1'b0;
    rd_src_d   = rd_src_q;
    byp_data_d = byp_data_q;
    if (in_act_read_en) begin
      if (!rd_ok) begin
        rd_miss_d = 1'b1;
        rd_src_d  = RD_SRC_ZERO;
      end else if (rd_byp) begin
        rd_src_d   = RD_SRC_BYP;
        byp_data_d = in_act_write_data;
      end else begin
        rd_src_d  = RD_SRC_MEM;
        rd_miss_d = !vld_bits_q[in_act_read_addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_bits_q <= '0;
      cnt_q      <= '0;
      loaded_q   <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_miss_q  <= 1'b0;
      rd_src_q   <= RD_SRC_ZERO;
    end else begin
      vld_bits_q <= vld_bits_d;
      cnt_q      <= cnt_d;
      loaded_q   <= loaded_d;
      rd_vld_q   <= rd_vld_d;
      rd_miss_q  <= rd_miss_d;
      rd_src_q   <= rd_src_d;
    end
  end

  always_ff @(posedge clk) begin
    byp_data_q <= byp_data_d;
  end

  pe_act_mem #(
    .DEPTH (ACT_NUM),
    .WIDTH (ACT_WIDTH),
    .AW    (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok && !rst),
    .waddr (in_act_write_addr),
    .wdata (in_act_write_data),
    .re    (rd_ok && !rd_byp && !rst),
    .raddr (in_act_read_addr),
    .rdata (mem_rdata)
  );

  always_comb begin
    in_act_read_data = '0;
    case (rd_src_q)
      RD_SRC_MEM: in_act_read_data = mem_rdata;
      RD_SRC_BYP: in_act_read_data = byp_data_q;
      default:    in_act_read_data = '0;
    endcase
  end

  assign in_act_read_valid = rd_vld_q;
  assign in_act_read_miss  = rd_miss_q;
  assign in_act_load_cnt   = cnt_q;
  assign in_act_loaded     = loaded_q;

endmodule
